// File: rtl/xs_dispatch_pkg.sv
// Shared dispatch-side types: ROB pointer, age compare and the FU codes used for routing.
package xs_dispatch_pkg;

    // Widest robIdx value any instance may use; narrower pointers are zero-extended into it.
    localparam int MAX_ROB_W = 16;

    localparam int FU_FMAC  = 8;
    localparam int FU_FMISC = 10;
    localparam int FU_FDIV  = 11;

    typedef struct packed {
        logic                 flag;
        logic [MAX_ROB_W-1:0] value;
    } rob_ptr_t;

    // True when a is younger than b; equal value with differing flag counts as younger.
    function automatic logic is_after(input rob_ptr_t a, input rob_ptr_t b);
        return (a.flag != b.flag) ^ (a.value > b.value);
    endfunction

endpackage

// File: rtl/dispatch_router_rr_select.sv
// Round-robin picker: rotate requests by ptr, take the lowest set bit, rotate the index back.
module rr_select
    import xs_dispatch_pkg::*;
#(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0] rot;
    logic         found;
    int unsigned  pick;
    int unsigned  pos;
    int unsigned  sel;

    always_comb begin
        rot   = '0;
        found = 1'b0;
        pick  = 0;
        pos   = 0;
        sel   = 0;
        for (int unsigned j = 0; j < N; j++) begin
            pos = j + ptr_i;
            if (pos >= N) pos = pos - N;
            rot[j] = req_i[pos];
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pick  = j;
            end
        end
        sel = pick + ptr_i;
        if (sel >= N) sel = sel - N;
        gnt_o = '0;
        if (found) gnt_o[sel] = 1'b1;
        idx_o = PW'(sel);
        any_o = found;
    end

endmodule

// File: rtl/dispatch_router.sv
// One-entry registered dispatch router: steers each uop to one RS port by fuType mask,
// round-robin among matching ports, and kills held/incoming uops younger than a redirect.
module dispatch_router
    import xs_dispatch_pkg::*;
#(
    parameter int NUM_OUT = 2,
    parameter int FU_W    = 4,
    parameter int ROB_W   = 5,
    parameter int DATA_W  = 128,
    parameter logic [NUM_OUT*(2**FU_W)-1:0] OUT_FU_MASK = 32'h0C00_0100
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_in_valid,
    output logic               io_in_ready,
    input  logic [FU_W-1:0]    io_in_fuType,
    input  logic               io_in_robIdx_flag,
    input  logic [ROB_W-1:0]   io_in_robIdx_value,
    input  logic [DATA_W-1:0]  io_in_payload,
    input  logic               io_redirect_valid,
    input  logic               io_redirect_robIdx_flag,
    input  logic [ROB_W-1:0]   io_redirect_robIdx_value,
    output logic [NUM_OUT-1:0] io_out_valid,
    input  logic [NUM_OUT-1:0] io_out_ready,
    output logic [FU_W-1:0]    io_out_fuType,
    output logic               io_out_robIdx_flag,
    output logic [ROB_W-1:0]   io_out_robIdx_value,
    output logic [DATA_W-1:0]  io_out_payload,
    output logic               io_dropUnroutable
);

    localparam int NFU = 2**FU_W;
    localparam int PW  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    logic               v_q, v_d;
    logic [NUM_OUT-1:0] sel_q, sel_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic               drop_q, drop_d;
    logic [FU_W-1:0]    fu_q;
    logic               flag_q;
    logic [ROB_W-1:0]   val_q;
    logic [DATA_W-1:0]  pay_q;

    logic [NUM_OUT-1:0] match, gnt;
    logic [NFU-1:0]     port_mask;
    logic [PW-1:0]      idx;
    logic               any;
    logic               out_fire, in_fire, in_kill, q_kill, load;
    rob_ptr_t           in_ptr, q_ptr, rd_ptr;

    always_comb begin
        match     = '0;
        port_mask = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            port_mask = OUT_FU_MASK[i*NFU +: NFU];
            match[i]  = port_mask[io_in_fuType];
        end
    end

    rr_select #(.N(NUM_OUT)) u_rr (
        .req_i (match),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (idx),
        .any_o (any)
    );

    always_comb begin
        in_ptr.flag  = io_in_robIdx_flag;
        in_ptr.value = MAX_ROB_W'(io_in_robIdx_value);
        q_ptr.flag   = flag_q;
        q_ptr.value  = MAX_ROB_W'(val_q);
        rd_ptr.flag  = io_redirect_robIdx_flag;
        rd_ptr.value = MAX_ROB_W'(io_redirect_robIdx_value);
    end

    assign io_out_valid = {NUM_OUT{v_q}} & sel_q;
    assign out_fire     = |(io_out_valid & io_out_ready);
    assign io_in_ready  = !v_q || out_fire;
    assign in_fire      = io_in_valid && io_in_ready;
    assign in_kill      = io_redirect_valid && is_after(in_ptr, rd_ptr);
    assign q_kill       = io_redirect_valid && v_q && is_after(q_ptr, rd_ptr);
    assign load         = in_fire && !in_kill && any;

    // A killed or fired entry empties unless a new uop replaces it on the same edge.
    always_comb begin
        v_d    = v_q;
        sel_d  = sel_q;
        rr_d   = rr_q;
        drop_d = 1'b0;
        if (out_fire || q_kill) v_d = 1'b0;
        if (in_fire && !in_kill) begin
            if (any) begin
                v_d   = 1'b1;
                sel_d = gnt;
                rr_d  = (idx == PW'(NUM_OUT - 1)) ? '0 : idx + 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v_q    <= 1'b0;
            sel_q  <= '0;
            rr_q   <= '0;
            drop_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            sel_q  <= sel_d;
            rr_q   <= rr_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clock) begin
        if (load) begin
            fu_q   <= io_in_fuType;
            flag_q <= io_in_robIdx_flag;
            val_q  <= io_in_robIdx_value;
            pay_q  <= io_in_payload;
        end
    end

    assign io_out_fuType       = fu_q;
    assign io_out_robIdx_flag  = flag_q;
    assign io_out_robIdx_value = val_q;
    assign io_out_payload      = pay_q;
    assign io_dropUnroutable   = drop_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ($onehot0(io_out_valid));
            assert (v_q || io_in_ready);
        end
    end

endmodule

// File: tb/tb_dispatch_router.sv
// Directed self-checking bench for dispatch_router; port 0 takes fuType 8/10, port 1 takes 10/11.
module tb_dispatch_router;

    logic         clock;
    logic         reset;
    logic         io_in_valid;
    logic         io_in_ready;
    logic [3:0]   io_in_fuType;
    logic         io_in_robIdx_flag;
    logic [4:0]   io_in_robIdx_value;
    logic [127:0] io_in_payload;
    logic         io_redirect_valid;
    logic         io_redirect_robIdx_flag;
    logic [4:0]   io_redirect_robIdx_value;
    logic [1:0]   io_out_valid;
    logic [1:0]   io_out_ready;
    logic [3:0]   io_out_fuType;
    logic         io_out_robIdx_flag;
    logic [4:0]   io_out_robIdx_value;
    logic [127:0] io_out_payload;
    logic         io_dropUnroutable;

    int n_checks = 0;
    int n_fail   = 0;

    dispatch_router #(
        .NUM_OUT     (2),
        .FU_W        (4),
        .ROB_W       (5),
        .DATA_W      (128),
        .OUT_FU_MASK (32'h0C00_0500)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_in_valid              (io_in_valid),
        .io_in_ready              (io_in_ready),
        .io_in_fuType             (io_in_fuType),
        .io_in_robIdx_flag        (io_in_robIdx_flag),
        .io_in_robIdx_value       (io_in_robIdx_value),
        .io_in_payload            (io_in_payload),
        .io_redirect_valid        (io_redirect_valid),
        .io_redirect_robIdx_flag  (io_redirect_robIdx_flag),
        .io_redirect_robIdx_value (io_redirect_robIdx_value),
        .io_out_valid             (io_out_valid),
        .io_out_ready             (io_out_ready),
        .io_out_fuType            (io_out_fuType),
        .io_out_robIdx_flag       (io_out_robIdx_flag),
        .io_out_robIdx_value      (io_out_robIdx_value),
        .io_out_payload           (io_out_payload),
        .io_dropUnroutable        (io_dropUnroutable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_uop(input logic [3:0] fu, input logic flag, input logic [4:0] val,
                             input logic [127:0] pay);
        io_in_valid        = 1'b1;
        io_in_fuType       = fu;
        io_in_robIdx_flag  = flag;
        io_in_robIdx_value = val;
        io_in_payload      = pay;
    endtask

    task automatic drive_redirect(input logic flag, input logic [4:0] val);
        io_redirect_valid        = 1'b1;
        io_redirect_robIdx_flag  = flag;
        io_redirect_robIdx_value = val;
    endtask

    task automatic do_reset;
        reset                    = 1'b1;
        io_in_valid              = 1'b0;
        io_in_fuType             = '0;
        io_in_robIdx_flag        = 1'b0;
        io_in_robIdx_value       = '0;
        io_in_payload            = '0;
        io_redirect_valid        = 1'b0;
        io_redirect_robIdx_flag  = 1'b0;
        io_redirect_robIdx_value = '0;
        io_out_ready             = 2'b00;
        step;
        step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++;
        if (io_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 00", io_out_valid);
        end
        n_checks++;
        if (io_dropUnroutable !== 1'b0) begin
            n_fail++; $display("FAIL reset_drop: got %b expected 0", io_dropUnroutable);
        end
        n_checks++;
        if (io_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", io_in_ready);
        end
    endtask

    task automatic test_basic;
        do_reset;
        io_out_ready = 2'b11;
        drive_uop(4'd8, 1'b0, 5'd1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
        #1;
        n_checks++;
        if (io_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_in_ready_pre: got %b expected 1", io_in_ready);
        end
        step;
        io_in_valid = 1'b0;
        #1;
        n_checks++;
        if (io_out_valid !== 2'b01) begin
            n_fail++; $display("FAIL basic_out_valid: got %b expected 01", io_out_valid);
        end
        n_checks++;
        if (io_out_payload !== 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555) begin
            n_fail++; $display("FAIL basic_payload: got %h expected deadbeef000011112222333344445555", io_out_payload);
        end
        n_checks++;
        if (io_out_fuType !== 4'd8 || io_out_robIdx_value !== 5'd1) begin
            n_fail++; $display("FAIL basic_fields: got fu=%0d rob=%0d expected fu=8 rob=1", io_out_fuType, io_out_robIdx_value);
        end
        n_checks++;
        if (io_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_in_ready_post: got %b expected 1", io_in_ready);
        end
        step;
        n_checks++;
        if (io_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL basic_drain: got %b expected 00", io_out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_v [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset;
        io_out_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            drive_uop(4'd10, 1'b0, 5'(k), 128'(32'h100 + k));
            step;
            n_checks++;
            if (io_out_valid !== exp_v[k] || io_out_payload !== 128'(32'h100 + k)) begin
                n_fail++; $display("FAIL rr_uop%0d: got valid=%b payload=%h expected valid=%b payload=%h",
                                   k, io_out_valid, io_out_payload, exp_v[k], 128'(32'h100 + k));
            end
            n_checks++;
            if (io_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL rr_in_ready%0d: got %b expected 1", k, io_in_ready);
            end
        end
        io_in_valid = 1'b0;
        step;
        n_checks++;
        if (io_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL rr_drain: got %b expected 00", io_out_valid);
        end
    endtask

    task automatic test_hold;
        do_reset;
        io_out_ready = 2'b00;
        drive_uop(4'd8, 1'b0, 5'd2, 128'hAAAA);
        step;
        drive_uop(4'd8, 1'b0, 5'd3, 128'hBBBB);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (io_out_valid !== 2'b01 || io_out_payload !== 128'hAAAA || io_out_robIdx_value !== 5'd2) begin
                n_fail++; $display("FAIL hold_stable%0d: got valid=%b payload=%h rob=%0d expected valid=01 payload=aaaa rob=2",
                                   c, io_out_valid, io_out_payload, io_out_robIdx_value);
            end
            n_checks++;
            if (io_in_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_in_ready%0d: got %b expected 0", c, io_in_ready);
            end
            step;
        end
        io_out_ready = 2'b11;
        #1;
        n_checks++;
        if (io_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_release_ready: got %b expected 1", io_in_ready);
        end
        step;
        io_in_valid = 1'b0;
        n_checks++;
        if (io_out_valid !== 2'b01 || io_out_payload !== 128'hBBBB || io_out_robIdx_value !== 5'd3) begin
            n_fail++; $display("FAIL hold_reload: got valid=%b payload=%h rob=%0d expected valid=01 payload=bbbb rob=3",
                               io_out_valid, io_out_payload, io_out_robIdx_value);
        end
        step;
        n_checks++;
        if (io_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL hold_drain: got %b expected 00", io_out_valid);
        end
    endtask

    task automatic test_drop;
        do_reset;
        io_out_ready = 2'b11;
        drive_uop(4'd3, 1'b0, 5'd4, 128'hCCCC);
        step;
        io_in_valid = 1'b0;
        n_checks++;
        if (io_dropUnroutable !== 1'b1 || io_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL drop_pulse: got drop=%b valid=%b expected drop=1 valid=00",
                               io_dropUnroutable, io_out_valid);
        end
        step;
        n_checks++;
        if (io_dropUnroutable !== 1'b0) begin
            n_fail++; $display("FAIL drop_single: got %b expected 0", io_dropUnroutable);
        end
    endtask

    task automatic test_redirect;
        // Held {0,7} younger than redirect {0,5}: still visible this cycle, gone next.
        do_reset;
        io_out_ready = 2'b00;
        drive_uop(4'd8, 1'b0, 5'd7, 128'h7777);
        step;
        io_in_valid = 1'b0;
        drive_redirect(1'b0, 5'd5);
        #1;
        n_checks++;
        if (io_out_valid !== 2'b01) begin
            n_fail++; $display("FAIL redir_same_cycle: got %b expected 01", io_out_valid);
        end
        step;
        io_redirect_valid = 1'b0;
        n_checks++;
        if (io_out_valid !== 2'b00 || io_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL redir_kill_held: got valid=%b ready=%b expected valid=00 ready=1",
                               io_out_valid, io_in_ready);
        end

        // Held {0,7} is older than redirect {1,2} across the wrap: kept.
        drive_uop(4'd8, 1'b0, 5'd7, 128'h7070);
        step;
        io_in_valid = 1'b0;
        drive_redirect(1'b1, 5'd2);
        step;
        n_checks++;
        if (io_out_valid !== 2'b01 || io_out_payload !== 128'h7070) begin
            n_fail++; $display("FAIL redir_keep_wrap: got valid=%b payload=%h expected valid=01 payload=7070",
                               io_out_valid, io_out_payload);
        end

        // Same value, different flag counts as younger: killed.
        drive_redirect(1'b1, 5'd7);
        step;
        io_redirect_valid = 1'b0;
        n_checks++;
        if (io_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL redir_equal_value: got %b expected 00", io_out_valid);
        end

        // Incoming younger uops in the redirect cycle vanish without a drop pulse.
        do_reset;
        io_out_ready = 2'b11;
        drive_uop(4'd8, 1'b0, 5'd9, 128'h9999);
        drive_redirect(1'b0, 5'd5);
        step;
        drive_uop(4'd3, 1'b0, 5'd9, 128'h9998);
        n_checks++;
        if (io_out_valid !== 2'b00 || io_dropUnroutable !== 1'b0) begin
            n_fail++; $display("FAIL redir_kill_incoming: got valid=%b drop=%b expected valid=00 drop=0",
                               io_out_valid, io_dropUnroutable);
        end
        step;
        io_redirect_valid = 1'b0;
        drive_uop(4'd10, 1'b0, 5'd1, 128'h1010);
        n_checks++;
        if (io_dropUnroutable !== 1'b0) begin
            n_fail++; $display("FAIL redir_kill_no_drop: got %b expected 0", io_dropUnroutable);
        end
        step;
        n_checks++;
        if (io_out_valid !== 2'b01) begin
            n_fail++; $display("FAIL redir_rr_unchanged: got %b expected 01", io_out_valid);
        end

        // Older incoming uop during a redirect proceeds; rr now points at port 1.
        drive_uop(4'd10, 1'b0, 5'd4, 128'h4040);
        drive_redirect(1'b0, 5'd5);
        step;
        io_in_valid       = 1'b0;
        io_redirect_valid = 1'b0;
        n_checks++;
        if (io_out_valid !== 2'b10 || io_out_payload !== 128'h4040) begin
            n_fail++; $display("FAIL redir_older_passes: got valid=%b payload=%h expected valid=10 payload=4040",
                               io_out_valid, io_out_payload);
        end
        step;
    endtask

    task automatic test_reset_mid;
        do_reset;
        io_out_ready = 2'b00;
        drive_uop(4'd8, 1'b0, 5'd6, 128'h6666);
        step;
        io_in_valid = 1'b0;
        n_checks++;
        if (io_out_valid !== 2'b01) begin
            n_fail++; $display("FAIL midreset_loaded: got %b expected 01", io_out_valid);
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        n_checks++;
        if (io_out_valid !== 2'b00 || io_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_cleared: got valid=%b ready=%b expected valid=00 ready=1",
                               io_out_valid, io_in_ready);
        end
        io_out_ready = 2'b11;
        drive_uop(4'd10, 1'b0, 5'd0, 128'h0A0A);
        step;
        io_in_valid = 1'b0;
        n_checks++;
        if (io_out_valid !== 2'b01) begin
            n_fail++; $display("FAIL midreset_rr_zero: got %b expected 01", io_out_valid);
        end
        step;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_hold;
        test_drop;
        test_redirect;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
